// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - opcodes, ALU-op codes and state encodings for the multicycle MIPS control FSM
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE = 2'b11;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_MEM_ADDR = 4'd2,
        ST_MEM_RD   = 4'd3,
        ST_MEM_WB   = 4'd4,
        ST_MEM_WR   = 4'd5,
        ST_R_EXEC   = 4'd6,
        ST_R_WB     = 4'd7,
        ST_BRANCH   = 4'd8,
        ST_JUMP     = 4'd9,
        ST_I_EXEC   = 4'd10,
        ST_I_WB     = 4'd11,
        ST_HALT     = 4'd12
    } state_t;

    function automatic logic op_supported(input logic [5:0] op, input logic bne_ok);
        case (op)
            OP_RTYPE, OP_J, OP_BEQ, OP_LW, OP_SW: return 1'b1;
            OP_BNE: return bne_ok;
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_main_control.sv
// rtl/multicycle_main_control.sv - main control FSM of the multicycle MIPS core
module multicycle_main_control
    import mips_ctrl_pkg::*;
#(
    parameter bit ILLEGAL_HALT = 1'b0,
    parameter bit ENABLE_BNE   = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       branch_ne,
    output logic [1:0] pc_source,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       imm_zext,
    output logic [1:0] alu_op,
    output logic [5:0] alu_func,
    output logic       instr_done,
    output logic       illegal_op,
    output logic [3:0] state_o
);

    state_t state, state_next;
    logic   op_legal;

    assign op_legal = op_supported(op, ENABLE_BNE);
    assign state_o  = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = ST_FETCH;
        case (state)
            ST_FETCH:    state_next = mem_ready ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                if (!op_legal)
                    state_next = ILLEGAL_HALT ? ST_HALT : ST_FETCH;
                else if (op == OP_LW || op == OP_SW)
                    state_next = ST_MEM_ADDR;
                else if (op == OP_RTYPE)
                    state_next = ST_R_EXEC;
                else if (op == OP_BEQ || op == OP_BNE)
                    state_next = ST_BRANCH;
                else if (op == OP_J)
                    state_next = ST_JUMP;
                else
                    state_next = ST_I_EXEC;
            end
            ST_MEM_ADDR: state_next = (op == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
            ST_MEM_RD:   state_next = mem_ready ? ST_MEM_WB : ST_MEM_RD;
            ST_MEM_WB:   state_next = ST_FETCH;
            ST_MEM_WR:   state_next = mem_ready ? ST_FETCH : ST_MEM_WR;
            ST_R_EXEC:   state_next = ST_R_WB;
            ST_R_WB:     state_next = ST_FETCH;
            ST_BRANCH:   state_next = ST_FETCH;
            ST_JUMP:     state_next = ST_FETCH;
            ST_I_EXEC:   state_next = ST_I_WB;
            ST_I_WB:     state_next = ST_FETCH;
            ST_HALT:     state_next = ST_HALT;
            default:     state_next = ST_FETCH;
        endcase
    end

    // Reset masks every enable so a memory access in flight is abandoned cleanly.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        branch_ne     = 1'b0;
        pc_source     = 2'b00;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        imm_zext      = 1'b0;
        alu_op        = ALUOP_ADD;
        alu_func      = 6'b000000;
        instr_done    = 1'b0;
        illegal_op    = 1'b0;
        if (!rst) begin
            case (state)
                ST_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                ST_DECODE: begin
                    alu_src_b  = 2'b11;
                    illegal_op = !op_legal;
                end
                ST_MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                ST_MEM_RD: begin
                    mem_read = 1'b1;
                    iord     = 1'b1;
                end
                ST_MEM_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    instr_done = 1'b1;
                end
                ST_MEM_WR: begin
                    mem_write  = 1'b1;
                    iord       = 1'b1;
                    instr_done = mem_ready;
                end
                ST_R_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALUOP_RTYPE;
                    alu_func  = funct;
                end
                ST_R_WB: begin
                    reg_write  = 1'b1;
                    reg_dst    = 1'b1;
                    alu_op     = ALUOP_RTYPE;
                    alu_func   = funct;
                    instr_done = 1'b1;
                end
                ST_BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_op        = ALUOP_SUB;
                    pc_write_cond = 1'b1;
                    pc_source     = 2'b01;
                    branch_ne     = (op == OP_BNE);
                    instr_done    = 1'b1;
                end
                ST_JUMP: begin
                    pc_write   = 1'b1;
                    pc_source  = 2'b10;
                    instr_done = 1'b1;
                end
                ST_I_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    alu_op    = ALUOP_ITYPE;
                    alu_func  = op;
                    imm_zext  = (op[5:2] == 4'b0011);
                end
                ST_I_WB: begin
                    reg_write  = 1'b1;
                    alu_op     = ALUOP_ITYPE;
                    alu_func   = op;
                    imm_zext   = (op[5:2] == 4'b0011);
                    instr_done = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_main_control.sv
// tb/tb_multicycle_main_control.sv - self-checking bench for multicycle_main_control
module tb_multicycle_main_control;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        logic [1:0] pc_source;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       imm_zext;
        logic [1:0] alu_op;
        logic [5:0] alu_func;
        logic       instr_done;
        logic       illegal_op;
    } outs_t;

    typedef struct {
        logic [3:0] st;
        bit         mem;
        outs_t      w;
        outs_t      r;
    } step_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst0 = 1'b1, rst1 = 1'b1, rdy0 = 1'b0, rdy1 = 1'b0;
    logic [5:0] op0 = '0, op1 = '0, funct0 = '0, funct1 = '0;
    logic       pcw0, pcwc0, bne0, iord0, mr0, mw0, irw0, rw0, rd0, m2r0, sa0, zx0, done0, ill0;
    logic       pcw1, pcwc1, bne1, iord1, mr1, mw1, irw1, rw1, rd1, m2r1, sa1, zx1, done1, ill1;
    logic [1:0] pcs0, sb0, aop0, pcs1, sb1, aop1;
    logic [5:0] af0, af1;
    logic [3:0] st0, st1;
    outs_t      obs0, obs1;

    assign obs0 = {pcw0, pcwc0, bne0, pcs0, iord0, mr0, mw0, irw0, rw0, rd0, m2r0, sa0, sb0, zx0, aop0, af0, done0, ill0};
    assign obs1 = {pcw1, pcwc1, bne1, pcs1, iord1, mr1, mw1, irw1, rw1, rd1, m2r1, sa1, sb1, zx1, aop1, af1, done1, ill1};

    multicycle_main_control #(.ILLEGAL_HALT(1'b0), .ENABLE_BNE(1'b1)) dut0 (
        .clk(clk), .rst(rst0), .op(op0), .funct(funct0), .mem_ready(rdy0),
        .pc_write(pcw0), .pc_write_cond(pcwc0), .branch_ne(bne0), .pc_source(pcs0),
        .iord(iord0), .mem_read(mr0), .mem_write(mw0), .ir_write(irw0), .reg_write(rw0),
        .reg_dst(rd0), .mem_to_reg(m2r0), .alu_src_a(sa0), .alu_src_b(sb0), .imm_zext(zx0),
        .alu_op(aop0), .alu_func(af0), .instr_done(done0), .illegal_op(ill0), .state_o(st0)
    );

    multicycle_main_control #(.ILLEGAL_HALT(1'b1), .ENABLE_BNE(1'b0)) dut1 (
        .clk(clk), .rst(rst1), .op(op1), .funct(funct1), .mem_ready(rdy1),
        .pc_write(pcw1), .pc_write_cond(pcwc1), .branch_ne(bne1), .pc_source(pcs1),
        .iord(iord1), .mem_read(mr1), .mem_write(mw1), .ir_write(irw1), .reg_write(rw1),
        .reg_dst(rd1), .mem_to_reg(m2r1), .alu_src_a(sa1), .alu_src_b(sb1), .imm_zext(zx1),
        .alu_op(aop1), .alu_func(af1), .instr_done(done1), .illegal_op(ill1), .state_o(st1)
    );

    int    checks = 0;
    int    failures = 0;
    int    dsel = 0;
    step_t steps[$];
    bit    ready_script[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] cur_state();
        return (dsel == 0) ? st0 : st1;
    endfunction

    function automatic outs_t cur_outs();
        return (dsel == 0) ? obs0 : obs1;
    endfunction

    task automatic set_in(input logic r, input logic [5:0] o, input logic [5:0] f, input logic rdy);
        if (dsel == 0) begin rst0 = r; op0 = o; funct0 = f; rdy0 = rdy; end
        else           begin rst1 = r; op1 = o; funct1 = f; rdy1 = rdy; end
    endtask

    task automatic set_ready(input logic rdy);
        if (dsel == 0) rdy0 = rdy; else rdy1 = rdy;
    endtask

    function automatic bit is_legal(input logic [5:0] o, input bit bne_en);
        return o == 6'd0 || o == 6'd2 || o == 6'd4 || o == 6'h23 || o == 6'h2b ||
               (o >= 6'd8 && o <= 6'd15) || (bne_en && o == 6'd5);
    endfunction

    function automatic bit next_ready();
        if (ready_script.size() > 0) return ready_script.pop_front();
        return $urandom_range(0, 99) < 65;
    endfunction

    task automatic push(input logic [3:0] st, input bit mem, input outs_t w, input outs_t r);
        step_t s;
        s.st = st; s.mem = mem; s.w = w; s.r = r;
        steps.push_back(s);
    endtask

    // Expected per-cycle trace of one instruction, built straight from the instruction's class.
    task automatic plan(input logic [5:0] o, input logic [5:0] f, input bit halt, input bit bne_en);
        outs_t z, a, b;
        z = '0;
        steps.delete();
        a = z; a.mem_read = 1; a.alu_src_b = 2'b01;
        b = a; b.ir_write = 1; b.pc_write = 1;
        push(4'd0, 1, a, b);
        a = z; a.alu_src_b = 2'b11; a.illegal_op = !is_legal(o, bne_en);
        push(4'd1, 0, a, a);
        if (!is_legal(o, bne_en)) begin
            if (halt) for (int i = 0; i < 6; i++) push(4'd12, 0, z, z);
        end else if (o == 6'h23 || o == 6'h2b) begin
            a = z; a.alu_src_a = 1; a.alu_src_b = 2'b10;
            push(4'd2, 0, a, a);
            if (o == 6'h23) begin
                a = z; a.mem_read = 1; a.iord = 1;
                push(4'd3, 1, a, a);
                a = z; a.reg_write = 1; a.mem_to_reg = 1; a.instr_done = 1;
                push(4'd4, 0, a, a);
            end else begin
                a = z; a.mem_write = 1; a.iord = 1;
                b = a; b.instr_done = 1;
                push(4'd5, 1, a, b);
            end
        end else if (o == 6'd0) begin
            a = z; a.alu_src_a = 1; a.alu_op = 2'b10; a.alu_func = f;
            push(4'd6, 0, a, a);
            a = z; a.reg_write = 1; a.reg_dst = 1; a.alu_op = 2'b10; a.alu_func = f; a.instr_done = 1;
            push(4'd7, 0, a, a);
        end else if (o == 6'd4 || o == 6'd5) begin
            a = z; a.alu_src_a = 1; a.alu_op = 2'b01; a.pc_write_cond = 1; a.pc_source = 2'b01;
            a.branch_ne = (o == 6'd5); a.instr_done = 1;
            push(4'd8, 0, a, a);
        end else if (o == 6'd2) begin
            a = z; a.pc_write = 1; a.pc_source = 2'b10; a.instr_done = 1;
            push(4'd9, 0, a, a);
        end else begin
            a = z; a.alu_src_a = 1; a.alu_src_b = 2'b10; a.alu_op = 2'b11; a.alu_func = o;
            a.imm_zext = (o >= 6'd12 && o <= 6'd15);
            push(4'd10, 0, a, a);
            a = z; a.reg_write = 1; a.alu_op = 2'b11; a.alu_func = o;
            a.imm_zext = (o >= 6'd12 && o <= 6'd15); a.instr_done = 1;
            push(4'd11, 0, a, a);
        end
    endtask

    // Called at a falling edge; plays the planned trace and returns at a falling edge.
    task automatic run_instr(input string tag, input logic [5:0] o, input logic [5:0] f);
        int    idx = 0;
        int    waits = 0;
        bit    r;
        outs_t e;
        plan(o, f, dsel != 0, dsel == 0);
        set_in(1'b0, o, f, 1'b0);
        while (idx < steps.size()) begin
            r = next_ready();
            if (waits >= 6) r = 1;
            set_ready(r);
            #1;
            e = (!steps[idx].mem || r) ? steps[idx].r : steps[idx].w;
            chk($sformatf("%s c%0d state", tag, idx), 32'(cur_state()), 32'(steps[idx].st));
            chk($sformatf("%s c%0d outs", tag, idx), 32'(cur_outs()), 32'(e));
            if (!steps[idx].mem || r) begin idx++; waits = 0; end
            else waits++;
            @(posedge clk); @(negedge clk);
        end
    endtask

    task automatic do_reset(input int n);
        set_in(1'b1, 6'($urandom), 6'($urandom), 1'($urandom));
        #1;
        chk("rst outs", 32'(cur_outs()), 32'd0);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); @(negedge clk);
            set_ready(1'($urandom));
            #1;
            chk("rst state", 32'(cur_state()), 32'd0);
            chk("rst outs held", 32'(cur_outs()), 32'd0);
        end
        @(negedge clk);
        set_in(1'b0, 6'd0, 6'd0, 1'b0);
    endtask

    function automatic logic [5:0] rand_op();
        logic [5:0] o;
        case ($urandom_range(0, 9))
            0: o = 6'h23;
            1: o = 6'h2b;
            2, 9: o = 6'd0;
            3: o = 6'd4;
            4: o = 6'd5;
            5: o = 6'd2;
            6, 7: o = 6'(6'd8 + 6'($urandom_range(0, 7)));
            default: begin
                o = 6'($urandom);
                while (is_legal(o, 1'b1)) o = 6'($urandom);
            end
        endcase
        return o;
    endfunction

    initial begin
        @(negedge clk);
        dsel = 0;
        do_reset(2);

        ready_script = '{0, 0, 1, 1, 1, 0, 1, 1};
        run_instr("lw_dir", 6'h23, 6'h00);
        ready_script = '{1, 1, 1, 1};
        run_instr("r_add", 6'h00, 6'b100000);
        run_instr("ori", 6'b001101, 6'h3f);
        run_instr("addi", 6'b001000, 6'h00);
        run_instr("bne", 6'b000101, 6'h00);
        run_instr("j", 6'b000010, 6'h00);
        run_instr("ill", 6'b111111, 6'h00);
        run_instr("sw", 6'h2b, 6'h00);
        run_instr("beq", 6'b000100, 6'h00);
        for (int i = 0; i < 80; i++)
            run_instr($sformatf("rnd%0d", i), rand_op(), 6'($urandom));

        // reset arriving while a load waits on memory
        set_in(1'b0, 6'h23, 6'h00, 1'b1);
        for (int i = 0; i < 3; i++) begin @(posedge clk); @(negedge clk); end
        set_ready(1'b0);
        #1;
        chk("rstrd pre state", 32'(cur_state()), 32'd3);
        @(posedge clk); @(negedge clk);
        set_in(1'b1, 6'h23, 6'h00, 1'b0);
        #1;
        chk("rstrd outs", 32'(cur_outs()), 32'd0);
        @(posedge clk); @(negedge clk);
        #1;
        chk("rstrd state", 32'(cur_state()), 32'd0);
        chk("rstrd outs2", 32'(cur_outs()), 32'd0);
        @(negedge clk);
        set_in(1'b0, 6'h00, 6'h00, 1'b0);
        run_instr("after_rst", 6'h00, 6'b100010);
        rst0 = 1'b1;

        dsel = 1;
        do_reset(1);
        run_instr("h_addi", 6'b001010, 6'h00);
        run_instr("h_bne_ill", 6'b000101, 6'h00);
        do_reset(1);
        run_instr("h_lw", 6'h23, 6'h00);
        run_instr("h_ill", 6'b110011, 6'h00);
        do_reset(1);
        run_instr("h_j", 6'b000010, 6'h00);
        #1;
        chk("final state", 32'(cur_state()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
